// File: rtl/vote_report_tx.sv
// Purpose : serial (UART-style) reporter sending HEADER, four snapshotted tallies and their 8-bit sum.
// Latency : start bit on the edge after send_req is seen in IDLE; done pulses 6*bits_per_byte*CLKS_PER_BIT cycles later.
// Backpres: send_req is sampled only while idle; requests during a frame are dropped, not queued.
// Optional: define VOTE_TX_PARITY_EN to add an even-parity bit after each byte's bit 7 (8E1 instead of 8N1).
module vote_report_tx #(
  parameter int          CLK_FREQ = 50000000,
  parameter int          BAUD     = 9600,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       send_req,
  input  logic [7:0] cand1_cnt,
  input  logic [7:0] cand2_cnt,
  input  logic [7:0] cand3_cnt,
  input  logic [7:0] cand4_cnt,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

`ifdef VOTE_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [2:0]    byte_idx_q, byte_idx_d;
  logic [7:0]    snap1_q, snap1_d, snap2_q, snap2_d, snap3_q, snap3_d, snap4_q, snap4_d;
  logic [7:0]    chk_q, chk_d;
  logic          tx_q, tx_d, busy_q, busy_d, done_q, done_d;

  logic [7:0]    cur_byte;
  logic [2:0]    next_bit;
  logic          bit_end;

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

  // Select the byte currently on the wire: header, four snapshots, checksum.
  always_comb begin
    cur_byte = chk_q;
    case (byte_idx_q)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = snap1_q;
      3'd2:    cur_byte = snap2_q;
      3'd3:    cur_byte = snap3_q;
      3'd4:    cur_byte = snap4_q;
      default: cur_byte = chk_q;
    endcase
  end

  // Next-state logic: each bit lasts CLKS_PER_BIT cycles; tx is precomputed so it leaves a flop.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    snap1_d    = snap1_q;
    snap2_d    = snap2_q;
    snap3_d    = snap3_q;
    snap4_d    = snap4_q;
    chk_d      = chk_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    next_bit   = bit_idx_q + 3'd1;
    bit_end    = (baud_cnt_q == LAST_CNT);

    case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        if (send_req) begin
          snap1_d    = cand1_cnt;
          snap2_d    = cand2_cnt;
          snap3_d    = cand3_cnt;
          snap4_d    = cand4_cnt;
          chk_d      = cand1_cnt + cand2_cnt + cand3_cnt + cand4_cnt;
          byte_idx_d = 3'd0;
          bit_idx_d  = 3'd0;
          busy_d     = 1'b1;
          tx_d       = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: begin
        baud_cnt_d = baud_cnt_q + 1'b1;
        if (bit_end) begin
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
          tx_d       = cur_byte[0];
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        baud_cnt_d = baud_cnt_q + 1'b1;
        if (bit_end) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef VOTE_TX_PARITY_EN
            tx_d    = ^cur_byte;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = next_bit;
            tx_d      = cur_byte[next_bit];
          end
        end
      end
`ifdef VOTE_TX_PARITY_EN
      S_PARITY: begin
        baud_cnt_d = baud_cnt_q + 1'b1;
        if (bit_end) begin
          baud_cnt_d = '0;
          tx_d       = 1'b1;
          state_d    = S_STOP;
        end
      end
`endif
      S_STOP: begin
        baud_cnt_d = baud_cnt_q + 1'b1;
        if (bit_end) begin
          baud_cnt_d = '0;
          if (byte_idx_q == 3'd5) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            tx_d       = 1'b0;
            state_d    = S_START;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame with the line idle-high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 3'd0;
      snap1_q    <= 8'd0;
      snap2_q    <= 8'd0;
      snap3_q    <= 8'd0;
      snap4_q    <= 8'd0;
      chk_q      <= 8'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      snap1_q    <= snap1_d;
      snap2_q    <= snap2_d;
      snap3_q    <= snap3_d;
      snap4_q    <= snap4_d;
      chk_q      <= chk_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_vote_report_tx.sv
// Bench for vote_report_tx at CLKS_PER_BIT=16: expected line waveform built from the frame bytes.
// Samples on the falling edge; every frame phase has a fixed cycle budget.
// Works with or without VOTE_TX_PARITY_EN.
module tb_vote_report_tx;

  localparam int CPB = 16;
`ifdef VOTE_TX_PARITY_EN
  localparam int BPB = 11;
`else
  localparam int BPB = 10;
`endif
  localparam int FRAME_BITS = 6 * BPB;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       send_req;
  logic [7:0] c1, c2, c3, c4;
  logic       tx, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  vote_report_tx #(.CLK_FREQ(160), .BAUD(10), .HEADER(8'hA5)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .send_req  (send_req),
    .cand1_cnt (c1),
    .cand2_cnt (c2),
    .cand3_cnt (c3),
    .cand4_cnt (c4),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: line level for serial bit n of a frame whose bytes are packed LSB-byte-first.
  function automatic logic model_bit(input logic [47:0] fr, input int n);
    int         b;
    int         p;
    logic [7:0] v;
    b = n / BPB;
    p = n % BPB;
    v = fr[b*8 +: 8];
    if (p == 0) return 1'b0;
    if (p <= 8) return v[p-1];
`ifdef VOTE_TX_PARITY_EN
    if (p == 9) return ^v;
`endif
    return 1'b1;
  endfunction

  // Idle for n cycles, counting any activity on busy/done/tx.
  task automatic idle(input int n, output int activity);
    activity = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (busy !== 1'b0 || done !== 1'b0 || tx !== 1'b1) activity++;
    end
  endtask

  // Must be called at a falling edge. mode 0: plain; 1: retrigger + change counts mid-frame;
  // 2: asynchronous reset during byte 2.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] d, input int mode);
    logic [47:0] fr;
    logic [7:0]  sum;
    logic [7:0]  got;
    int          ok;
    int          busy_hi;
    int          done_seen;
    int          n;
    int          k;
    int          p;
    sum = a + b + c + d;
    fr  = {sum, d, c, b, a, 8'hA5};
    got = 8'h00;
    ok = 0; busy_hi = 0; done_seen = 0;
    c1 = a; c2 = b; c3 = c; c4 = d;
    send_req = 1'b1;
    @(negedge clock);
    send_req = 1'b0;
    for (int cyc = 0; cyc < FRAME_BITS * CPB; cyc++) begin
      n = cyc / CPB;
      k = cyc % CPB;
      p = n % BPB;
      if (tx === model_bit(fr, n)) ok++;
      if (busy === 1'b1) busy_hi++;
      if (done === 1'b1) done_seen++;
      if (k == CPB / 2 && p >= 1 && p <= 8) got[p-1] = tx;
      if (k == CPB - 1) begin
        check("bit_level", ok, CPB);
        ok = 0;
        if (p == BPB - 1) check("byte_value", got, fr[(n / BPB)*8 +: 8]);
      end
      if (mode == 2 && n == 2 * BPB + 4 && k == 5) begin
        #2 reset_n = 1'b0;
        #1;
        check("abort_tx", tx, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        return;
      end
      if (mode == 1) begin
        send_req = ((cyc % 200) == 100);
        if (cyc == 150) begin
          c1 = 8'h09; c2 = 8'h09; c3 = 8'h09; c4 = 8'h09;
        end
      end
      @(negedge clock);
    end
    send_req = 1'b0;
    check("done_pulse", done, 1'b1);
    check("end_busy", busy, 1'b0);
    check("end_tx", tx, 1'b1);
    check("busy_cycles", busy_hi, FRAME_BITS * CPB);
    check("early_done", done_seen, 0);
  endtask

  initial begin
    int act;
    reset_n  = 1'b1;
    send_req = 1'b0;
    c1 = 8'd0; c2 = 8'd0; c3 = 8'd0; c4 = 8'd0;

    // Asynchronous reset before any clock edge.
    #3 reset_n = 1'b0;
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    idle(4, act);
    check("post_rst_idle", act, 0);

    // Directed frames.
    send_frame(8'd3, 8'd1, 8'd0, 8'd2, 0);
    idle(5, act);
    check("idle_after_1", act, 0);
    send_frame(8'hFF, 8'hFF, 8'h01, 8'h00, 0);
    idle(3, act);
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 1);
    idle(50, act);
    check("no_queued_frame", act, 0);
    send_frame(8'h10, 8'h20, 8'h30, 8'h40, 2);
    idle(40, act);
    check("abort_quiet", act, 0);
    send_frame(8'h10, 8'h20, 8'h30, 8'h40, 0);
    idle(2, act);
    send_frame(8'd1, 8'd0, 8'd0, 8'd0, 0);
    // Back-to-back: request on the done cycle.
    send_frame(8'h80, 8'h80, 8'h7F, 8'h01, 0);

    // Random frames, sometimes back-to-back.
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        idle(int'($urandom_range(20, 1)), act);
        check("rand_idle", act, 0);
      end
      send_frame(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
                 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
